// File: rtl/color_ram_arbiter_if.sv
// Bus bundle between the color RAM arbiter, the CPU/pixel sources and the 2149 RAM slices.
interface color_ram_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic          pix_en;
    logic          blank;
    logic [AW-1:0] pix_addr;
    logic          cpu_sel_b;
    logic          cpu_rw_b;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack_b;
    logic [AW-1:0] ram_addr;
    logic          ram_we_b;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] pix_color;
    logic          pix_valid;
    logic [7:0]    steal_cnt;

    modport slave (
        input  pix_en, blank, pix_addr, cpu_sel_b, cpu_rw_b, cpu_addr, cpu_wdata, ram_dout,
        output cpu_rdata, cpu_ack_b, ram_addr, ram_we_b, ram_din, pix_color, pix_valid, steal_cnt
    );

    modport master (
        output pix_en, blank, pix_addr, cpu_sel_b, cpu_rw_b, cpu_addr, cpu_wdata, ram_dout,
        input  cpu_rdata, cpu_ack_b, ram_addr, ram_we_b, ram_din, pix_color, pix_valid, steal_cnt
    );
endinterface

// File: rtl/color_ram_arbiter.sv
// Single-port color RAM arbiter: video lookups own pixel strobes, the CPU fills free
// cycles and steals one pixel slot after waiting MAX_WAIT cycles.
module color_ram_arbiter #(
    parameter int MAX_WAIT = 15,
    parameter int AW       = 10,
    parameter int DW       = 16
) (
    input  logic               clk,
    input  logic               rst_b,
    color_ram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ, ACCESS, DATA, ACK} state_t;
    typedef enum logic [1:0] {PK_LOOKUP, PK_BLANK, PK_STOLEN} pix_kind_t;

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    state_t    state, state_nxt;
    logic [7:0] wait_cnt;
    logic      vid_req, force_steal, cpu_gnt, vid_gnt;
    logic [1:0] vld_pipe;
    pix_kind_t kind0, kind1;

    always_comb begin
        vid_req     = bus.pix_en & ~bus.blank;
        force_steal = (state == REQ) & ~bus.cpu_sel_b & (wait_cnt == WAIT_MAX);
        cpu_gnt     = (state == REQ) & ~bus.cpu_sel_b & (~vid_req | force_steal);
        vid_gnt     = vid_req & ~force_steal;
        state_nxt   = state;
        case (state)
            IDLE:    if (!bus.cpu_sel_b && bus.cpu_ack_b) state_nxt = REQ;
            REQ:     if (bus.cpu_sel_b) state_nxt = IDLE;
                     else if (cpu_gnt)  state_nxt = ACCESS;
            // ram_we_b still carries the registered direction of the granted access
            ACCESS:  if (bus.cpu_sel_b)     state_nxt = IDLE;
                     else if (bus.ram_we_b) state_nxt = DATA;
                     else                   state_nxt = ACK;
            DATA:    state_nxt = bus.cpu_sel_b ? IDLE : ACK;
            ACK:     if (bus.cpu_sel_b) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // wait_cnt counts REQ cycles including the entry cycle
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            bus.cpu_ack_b <= 1'b1;
            bus.cpu_rdata <= '0;
        end else begin
            state         <= state_nxt;
            bus.cpu_ack_b <= (state_nxt != ACK);
            if (state_nxt != REQ)      wait_cnt <= 8'd0;
            else if (state != REQ)     wait_cnt <= 8'd1;
            else if (wait_cnt < WAIT_MAX) wait_cnt <= wait_cnt + 8'd1;
            if (state == DATA) bus.cpu_rdata <= bus.ram_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bus.ram_addr <= '0;
            bus.ram_din  <= '0;
            bus.ram_we_b <= 1'b1;
        end else if (cpu_gnt) begin
            bus.ram_addr <= bus.cpu_addr;
            bus.ram_din  <= bus.cpu_wdata;
            bus.ram_we_b <= bus.cpu_rw_b;
        end else if (vid_gnt) begin
            bus.ram_addr <= bus.pix_addr;
            bus.ram_we_b <= 1'b1;
        end else begin
            bus.ram_we_b <= 1'b1;
        end
    end

    // Two-stage strobe pipeline lines up with the synchronous RAM read
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            vld_pipe      <= '0;
            kind0         <= PK_LOOKUP;
            kind1         <= PK_LOOKUP;
            bus.pix_valid <= 1'b0;
            bus.pix_color <= '0;
            bus.steal_cnt <= 8'd0;
        end else begin
            vld_pipe      <= {vld_pipe[0], bus.pix_en};
            kind0         <= bus.blank ? PK_BLANK : (force_steal ? PK_STOLEN : PK_LOOKUP);
            kind1         <= kind0;
            bus.pix_valid <= vld_pipe[1];
            if (vld_pipe[1]) begin
                case (kind1)
                    PK_LOOKUP: bus.pix_color <= bus.ram_dout;
                    PK_BLANK:  bus.pix_color <= '0;
                    default:   bus.pix_color <= bus.pix_color;
                endcase
            end
            if (vid_req && force_steal && bus.steal_cnt != 8'hFF)
                bus.steal_cnt <= bus.steal_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_color_ram_arbiter.sv
// Bench for color_ram_arbiter: directed scenarios plus a randomized pixel/CPU mix
// checked against a queue-and-array reference.
module tb_color_ram_arbiter;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int MAX_WAIT = 15;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    color_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    color_ram_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_b(rst_b), .bus(bus));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit pix_done;

    // synchronous RAM model with a backdoor load port
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (!bus.ram_we_b) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    typedef struct { logic [DW-1:0] c; int due; } pix_exp_t;
    pix_exp_t exp_q[$];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        step;
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic cpu_access(input logic rw_b, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              output int lat, output int we_lows, output logic [DW-1:0] rd);
        bus.cpu_sel_b = 1'b0; bus.cpu_rw_b = rw_b; bus.cpu_addr = a; bus.cpu_wdata = d;
        lat = -1; we_lows = 0;
        for (int i = 1; i <= 40; i++) begin
            step;
            if (!bus.ram_we_b) we_lows++;
            if (!bus.cpu_ack_b) begin lat = i; break; end
        end
        rd = bus.cpu_rdata;
        bus.cpu_sel_b = 1'b1; bus.cpu_rw_b = 1'b1;
        step; step;
    endtask

    task automatic test_reset;
        logic [68:0] got, want;
        rst_b = 1'b0;
        step;
        got  = {bus.cpu_ack_b, bus.ram_we_b, bus.ram_addr, bus.ram_din, bus.cpu_rdata,
                bus.pix_color, bus.pix_valid, bus.steal_cnt};
        want = {1'b1, 1'b1, 10'd0, 16'd0, 16'd0, 16'd0, 1'b0, 8'd0};
        checks++;
        if (got !== want) begin
            failures++; $display("FAIL reset_state got=%h want=%h", got, want);
        end
        rst_b = 1'b1;
        step;
    endtask

    task automatic test_blank_write_read;
        int lat, wl; logic [DW-1:0] rd;
        bus.blank = 1'b1; bus.pix_en = 1'b0;
        cpu_access(1'b0, 10'h2A5, 16'h1234, lat, wl, rd);
        checks++;
        if (lat !== 3 || wl !== 1) begin
            failures++; $display("FAIL blank_write ack_edge=%0d we_low=%0d want 3/1", lat, wl);
        end
        checks++;
        if (mem[10'h2A5] !== 16'h1234) begin
            failures++; $display("FAIL blank_write_ram got=%h want=1234", mem[10'h2A5]);
        end
        ref_mem[10'h2A5] = 16'h1234;
        cpu_access(1'b1, 10'h2A5, 16'h0, lat, wl, rd);
        checks++;
        if (lat !== 4 || rd !== 16'h1234 || wl !== 0) begin
            failures++; $display("FAIL blank_read ack_edge=%0d data=%h want 4/1234", lat, rd);
        end
    endtask

    task automatic test_video_gap;
        logic ov [40]; logic [DW-1:0] oc [40];
        int ack_edge = -1, wl = 0; logic [DW-1:0] rd = '0;
        poke(10'h010, 16'hBEEF);
        bus.blank = 1'b0; bus.pix_addr = 10'h010;
        for (int t = 0; t < 30; t++) begin
            bus.pix_en = (t % 2 == 0);
            if (t == 3) begin bus.cpu_sel_b = 1'b0; bus.cpu_rw_b = 1'b1; bus.cpu_addr = 10'h2A5; end
            if (ack_edge >= 0) bus.cpu_sel_b = 1'b1;
            step;
            ov[t+1] = bus.pix_valid; oc[t+1] = bus.pix_color;
            if (!bus.ram_we_b) wl++;
            if (!bus.cpu_ack_b && ack_edge < 0) begin ack_edge = t + 1; rd = bus.cpu_rdata; end
        end
        bus.pix_en = 1'b0;
        step; step;
        checks++;
        if (ack_edge !== 8 || rd !== 16'h1234 || wl !== 0) begin
            failures++; $display("FAIL gap_read ack_edge=%0d data=%h want 8/1234", ack_edge, rd);
        end
        for (int i = 3; i <= 30; i++) begin
            checks++;
            if (ov[i] !== (i % 2 == 1) || (ov[i] && oc[i] !== 16'hBEEF)) begin
                failures++; $display("FAIL gap_pixel edge=%0d valid=%b color=%h want %b/BEEF",
                                     i, ov[i], oc[i], (i % 2 == 1));
            end
        end
        checks++;
        if (bus.steal_cnt !== 8'd0) begin
            failures++; $display("FAIL gap_steal got=%0d want 0", bus.steal_cnt);
        end
    endtask

    task automatic test_reset_mid_write;
        int lat, wl; logic [DW-1:0] rd;
        poke(10'h0C3, 16'h1111);
        bus.blank = 1'b1; bus.pix_en = 1'b0;
        bus.cpu_sel_b = 1'b0; bus.cpu_rw_b = 1'b0; bus.cpu_addr = 10'h0C3; bus.cpu_wdata = 16'h9999;
        step; step;
        checks++;
        if (bus.ram_we_b !== 1'b0) begin
            failures++; $display("FAIL midwrite_pre we_b=%b want 0", bus.ram_we_b);
        end
        rst_b = 1'b0;
        #1;
        checks++;
        if (bus.ram_we_b !== 1'b1 || bus.cpu_ack_b !== 1'b1 || bus.pix_color !== 16'h0) begin
            failures++; $display("FAIL midwrite_async we_b=%b ack_b=%b color=%h want 1/1/0000",
                                 bus.ram_we_b, bus.cpu_ack_b, bus.pix_color);
        end
        step;
        bus.cpu_sel_b = 1'b1; bus.cpu_rw_b = 1'b1;
        rst_b = 1'b1;
        step;
        checks++;
        if (mem[10'h0C3] !== 16'h1111) begin
            failures++; $display("FAIL midwrite_abort ram=%h want 1111", mem[10'h0C3]);
        end
        cpu_access(1'b1, 10'h0C3, 16'h0, lat, wl, rd);
        checks++;
        if (lat !== 4 || rd !== 16'h1111) begin
            failures++; $display("FAIL midwrite_idle ack_edge=%0d data=%h want 4/1111", lat, rd);
        end
    endtask

    task automatic test_steal;
        logic ov [50]; logic [DW-1:0] oc [50]; logic [DW-1:0] vals [48]; logic [DW-1:0] expc [50];
        logic [DW-1:0] v3f0, prev, rd = '0;
        int ack_edge = -1;
        int steal_edge = 3 + MAX_WAIT;
        for (int i = 0; i < 48; i++) begin
            vals[i] = 16'(i * 16'h0101 + 16'h0F00);
            poke(10'(10'h100 + i), vals[i]);
        end
        v3f0 = 16'($urandom);
        poke(10'h3F0, v3f0);
        bus.blank = 1'b0;
        for (int t = 0; t < 45; t++) begin
            bus.pix_en = 1'b1; bus.pix_addr = 10'(10'h100 + t);
            if (t == 2) begin bus.cpu_sel_b = 1'b0; bus.cpu_rw_b = 1'b1; bus.cpu_addr = 10'h3F0; end
            if (ack_edge >= 0) bus.cpu_sel_b = 1'b1;
            step;
            ov[t+1] = bus.pix_valid; oc[t+1] = bus.pix_color;
            if (!bus.cpu_ack_b && ack_edge < 0) begin ack_edge = t + 1; rd = bus.cpu_rdata; end
        end
        bus.pix_en = 1'b0;
        step; step;
        prev = '0;
        for (int t = 0; t < 43; t++) begin
            expc[t+3] = (t + 1 == steal_edge) ? prev : vals[t];
            prev = expc[t+3];
        end
        checks++;
        if (ack_edge !== steal_edge + 2 || rd !== v3f0) begin
            failures++; $display("FAIL steal_read ack_edge=%0d data=%h want %0d/%h",
                                 ack_edge, rd, steal_edge + 2, v3f0);
        end
        for (int i = 3; i <= 45; i++) begin
            checks++;
            if (ov[i] !== 1'b1 || oc[i] !== expc[i]) begin
                failures++; $display("FAIL steal_pixel edge=%0d valid=%b color=%h want 1/%h",
                                     i, ov[i], oc[i], expc[i]);
            end
        end
        checks++;
        if (bus.steal_cnt !== 8'd1) begin
            failures++; $display("FAIL steal_cnt got=%0d want 1", bus.steal_cnt);
        end
    endtask

    task automatic test_abort;
        int wl = 0, al = 0, lat; logic [DW-1:0] rd;
        bus.blank = 1'b0; bus.pix_addr = 10'h010;
        for (int t = 0; t < 16; t++) begin
            bus.pix_en = 1'b1;
            if (t == 1) begin bus.cpu_sel_b = 1'b0; bus.cpu_rw_b = 1'b1; bus.cpu_addr = 10'h2A5; end
            if (t == 6) bus.cpu_sel_b = 1'b1;
            step;
            if (!bus.ram_we_b) wl++;
            if (!bus.cpu_ack_b) al++;
        end
        checks++;
        if (wl !== 0 || al !== 0 || bus.steal_cnt !== 8'd1) begin
            failures++; $display("FAIL abort_req we_lows=%0d acks=%0d steal=%0d want 0/0/1",
                                 wl, al, bus.steal_cnt);
        end
        bus.pix_en = 1'b0; bus.blank = 1'b1;
        poke(10'h155, 16'h0000);
        bus.cpu_sel_b = 1'b0; bus.cpu_rw_b = 1'b0; bus.cpu_addr = 10'h155; bus.cpu_wdata = 16'h0BAD;
        step; step;
        bus.cpu_sel_b = 1'b1; bus.cpu_rw_b = 1'b1;
        al = 0;
        for (int t = 0; t < 6; t++) begin
            step;
            if (!bus.cpu_ack_b) al++;
        end
        checks++;
        if (al !== 0 || mem[10'h155] !== 16'h0BAD) begin
            failures++; $display("FAIL abort_access acks=%0d ram=%h want 0/0BAD", al, mem[10'h155]);
        end
        ref_mem[10'h155] = 16'h0BAD;
        cpu_access(1'b1, 10'h155, 16'h0, lat, wl, rd);
        checks++;
        if (lat !== 4 || rd !== 16'h0BAD) begin
            failures++; $display("FAIL abort_readback ack_edge=%0d data=%h want 4/0BAD", lat, rd);
        end
    endtask

    task automatic test_blank_pix;
        logic ov [30]; logic [DW-1:0] oc [30]; logic [AW-1:0] oa [30];
        bus.blank = 1'b1;
        for (int t = 0; t < 21; t++) begin
            bus.pix_en = (t % 3 == 0); bus.pix_addr = 10'($urandom);
            step;
            ov[t+1] = bus.pix_valid; oc[t+1] = bus.pix_color; oa[t+1] = bus.ram_addr;
        end
        bus.pix_en = 1'b0;
        for (int i = 3; i <= 21; i++) begin
            checks++;
            if (ov[i] !== ((i - 3) % 3 == 0) || (ov[i] && oc[i] !== 16'h0) || oa[i] !== 10'h155) begin
                failures++; $display("FAIL blank_pix edge=%0d valid=%b color=%h addr=%h want %b/0000/155",
                                     i, ov[i], oc[i], oa[i], ((i - 3) % 3 == 0));
            end
        end
    endtask

    task automatic test_random;
        rst_b = 1'b0; step; rst_b = 1'b1; step;
        for (int a = 0; a < (1 << AW); a++) poke(10'(a), 16'($urandom));
        exp_q.delete();
        pix_done = 1'b0;
        fork
            begin
                int run = 0;
                for (int n = 0; n < 1500; n++) begin
                    logic pe;
                    pe = ($urandom_range(0, 1) == 1) && (run < 3);
                    run = pe ? run + 1 : 0;
                    bus.pix_en = pe;
                    bus.blank = ($urandom_range(0, 3) == 0);
                    bus.pix_addr = 10'($urandom_range(0, 511));
                    if (pe) exp_q.push_back('{c: bus.blank ? 16'h0 : ref_mem[bus.pix_addr], due: cyc + 3});
                    step;
                end
                bus.pix_en = 1'b0;
                pix_done = 1'b1;
            end
            begin
                while (!pix_done) begin
                    int lat, wl; logic [DW-1:0] rd, d; logic [AW-1:0] a; logic rw;
                    repeat ($urandom_range(0, 3)) step;
                    rw = $urandom_range(0, 1) == 1;
                    a = rw ? 10'($urandom) : 10'($urandom_range(512, 1023));
                    d = 16'($urandom);
                    cpu_access(rw, a, d, lat, wl, rd);
                    checks++;
                    if (lat < 0 || (rw && rd !== ref_mem[a])) begin
                        failures++; $display("FAIL rand_cpu rw=%b addr=%h ack_edge=%0d data=%h want %h",
                                             rw, a, lat, rd, ref_mem[a]);
                    end
                    if (!rw) ref_mem[a] = d;
                end
            end
            begin
                for (int n = 0; n < 1510; n++) begin
                    step;
                    if (bus.pix_valid) begin
                        pix_exp_t e;
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++; $display("FAIL rand_pix_extra cyc=%0d color=%h want none",
                                                 cyc, bus.pix_color);
                        end else begin
                            e = exp_q.pop_front();
                            if (bus.pix_color !== e.c || cyc !== e.due) begin
                                failures++; $display("FAIL rand_pix cyc=%0d color=%h want cyc=%0d color=%h",
                                                     cyc, bus.pix_color, e.due, e.c);
                            end
                        end
                    end
                end
            end
        join
        checks++;
        if (exp_q.size() !== 0 || bus.steal_cnt !== 8'd0) begin
            failures++; $display("FAIL rand_end pending=%0d steal=%0d want 0/0", exp_q.size(), bus.steal_cnt);
        end
    endtask

    initial begin
        bus.pix_en = 1'b0; bus.blank = 1'b1; bus.pix_addr = '0;
        bus.cpu_sel_b = 1'b1; bus.cpu_rw_b = 1'b1; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        test_reset();
        test_blank_write_read();
        test_video_gap();
        test_reset_mid_write();
        test_steal();
        test_abort();
        test_blank_pix();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/color_ram_arbiter.md
Name: color_ram_arbiter

Overview:
Shares the single-port 1024x16 color RAM between the video pixel-lookup path and 68010 CPU accesses. Video lookups have priority on pixel strobes. CPU reads and writes fill the free cycles, with a bounded-wait steal so the CPU is never starved. The block sits between the address decoder/CPU bus, the priority-mux palette index, and the four 2149 RAM slices. It drives the RAM address, write strobe and write data, and returns CPU read data, a DTACK-style acknowledge and the registered pixel color.

Parameters:
MAX_WAIT, 15, CPU wait cycles in REQ after which the next pixel slot is stolen (1..255)
AW, 10, RAM address width
DW, 16, RAM data width

Ports:
clk  input  1  system clock
rst_b  input  1  asynchronous active-low reset
pix_en  input  1  pixel strobe, one-cycle pulse per pixel (MCKF-derived), may be high every cycle
blank  input  1  1 = blanking, no RAM lookup needed
pix_addr  input  AW  palette index {CRAS, latched index}
cpu_sel_b  input  1  CRAM select, active low, held for the whole bus cycle
cpu_rw_b  input  1  BR_W_b: 1 = read, 0 = write
cpu_addr  input  AW  CPU word address (MA)
cpu_wdata  input  DW  CPU write data (VBD)
cpu_rdata  output  DW  captured CPU read data
cpu_ack_b  output  1  acknowledge, active low
ram_addr  output  AW  RAM address, registered
ram_we_b  output  1  RAM write enable, active low, registered
ram_din  output  DW  RAM write data, registered
ram_dout  input  DW  RAM read data; synchronous RAM, valid after the edge following the address edge
pix_color  output  DW  color to monitor interface
pix_valid  output  1  one-cycle pulse when pix_color is updated
steal_cnt  output  8  saturating count of stolen video slots

Behaviour:
- Reset (async, rst_b=0): state=IDLE; cpu_ack_b=1; ram_we_b=1 immediately, which aborts any in-flight write; ram_addr=0; ram_din=0; cpu_rdata=0; pix_color=0; pix_valid=0; wait counter=0; steal_cnt=0; video pipeline flushed.
- CPU FSM states:
  - IDLE: go to REQ when cpu_sel_b=0 and cpu_ack_b=1.
  - REQ: wait counter increments each cycle, saturating at MAX_WAIT. Go to ACCESS on grant. Go to IDLE with no RAM access if cpu_sel_b returns to 1.
  - ACCESS: one cycle. Write goes to ACK. Read goes to DATA.
  - DATA: cpu_rdata<=ram_dout; go to ACK.
  - ACK: cpu_ack_b=0; stay until cpu_sel_b=1, then cpu_ack_b=1 and go to IDLE.
  - ACCESS or DATA with cpu_sel_b=1: the access completes (a write still commits), then go to IDLE without acknowledging.
- Port ownership is decided at each edge, one owner only:
  - vid_req = pix_en & ~blank.
  - force = (state==REQ) & (wait==MAX_WAIT).
  - CPU granted if state==REQ & (~vid_req | force). On grant: ram_addr<=cpu_addr; ram_din<=cpu_wdata; ram_we_b<=cpu_rw_b; wait<=0.
  - Video granted if vid_req & ~force: ram_addr<=pix_addr, ram_we_b<=1.
  - Otherwise ram_we_b<=1 and ram_addr holds.
- ram_we_b is low for exactly one cycle per write.
- Video latency: pix_en sampled at edge k gives pix_color/pix_valid updated at edge k+2. Every pix_en produces exactly one pix_valid, in order.
  - Granted: pix_color<=ram_dout.
  - blank=1: pix_color<=0.
  - Stolen (force): pix_color holds its previous value; steal_cnt increments, saturating at 255.
- CPU read latency from grant edge g: cpu_rdata valid and cpu_ack_b=0 at edge g+2. Write: cpu_ack_b=0 at edge g+1.
- Back-to-back CPU accesses require cpu_sel_b to go high between them.
- RAM write-then-read to the same address returns the new data. Writes have no bypass; the ordering guarantees this.

Test Plan:
- Reset mid-write (rst_b low while ram_we_b=0) -> ram_we_b=1, cpu_ack_b=1, pix_color=0 asynchronously; state=IDLE after release.
- Blanking (blank=1), CPU write 0x1234 to 0x2A5, then read 0x2A5 -> ram_we_b low one cycle at grant+0; write ack at g+1; read cpu_rdata=0x1234 with ack at g+2.
- Active video, pix_en every other cycle, pix_addr=0x010 with RAM[0x010]=0xBEEF -> pix_color=0xBEEF two edges after each strobe; CPU read is granted in the gap cycles and steal_cnt stays 0.
- pix_en every cycle, blank=0, CPU read pending -> grant exactly MAX_WAIT(15) cycles after entering REQ; that pixel's pix_valid pulses with pix_color unchanged; steal_cnt=1.
- cpu_sel_b released while in REQ -> no RAM access and no ack. Released while in ACCESS with a write -> RAM updated, cpu_ack_b stays 1.
- blank=1 with pix_en pulses -> pix_color=0 at k+2 and ram_addr does not follow pix_addr.
